// File: rtl/bp_pkg.sv
// Shared branch-resolution types: datapath width, BHT index slice and the
// ID/EX pipeline slot layout.
package bp_pkg;

  localparam int XLEN        = 32;
  localparam int BHT_IDX_W   = 8;
  localparam int BHT_IDX_LSB = 2;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } slot_t;

endpackage

// File: rtl/bp_pipe_slot.sv
// One pipeline slot: clear beats hold, hold beats load. Only the valid bit is
// reset; the payload is qualified by valid and left unreset.
module bp_pipe_slot
  import bp_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load_i,
  input  logic  hold_i,
  input  logic  clear_i,
  input  slot_t d_i,
  output slot_t q_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q;
  logic            pred_taken_q;
  logic [XLEN-1:0] pred_target_q;
  logic            capture;

  assign capture = load_i && !hold_i && !clear_i;

  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = d_i.valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      pc_q          <= d_i.pc;
      pred_taken_q  <= d_i.pred_taken;
      pred_target_q <= d_i.pred_target;
    end
  end

  assign q_o = {valid_q, pc_q, pred_taken_q, pred_target_q};

endmodule

// File: rtl/branch_resolve.sv
// Resolves the EX-slot branch against its prediction; BHT update, redirect and flush
// are registered (one cycle after resolution). Stall holds both slots. Optional counters: BRANCH_STATS_EN.
module branch_resolve
  import bp_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_valid,
  input  logic [XLEN-1:0]      if_pc,
  input  logic                 if_predict_taken,
  input  logic [XLEN-1:0]      if_pred_target,
  input  logic                 stall,
  input  logic                 ex_is_branch,
  input  logic                 ex_actual_taken,
  input  logic [XLEN-1:0]      ex_actual_target,
  output logic                 bht_update_en,
  output logic                 bht_actual_taken,
  output logic [BHT_IDX_W-1:0] bht_pc_index,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 flush,
  output logic [XLEN-1:0]      branch_count,
  output logic [XLEN-1:0]      mispredict_count
);

  slot_t if_slot, id_q, ex_q;

  logic                 update_en_q, update_en_d;
  logic                 actual_taken_q, actual_taken_d;
  logic [BHT_IDX_W-1:0] idx_q, idx_d;
  logic                 redirect_q, redirect_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
  logic                 flush_q, flush_d;

  logic resolve, dir_miss, tgt_miss, mispredict;

  assign if_slot = {if_valid, if_pc, if_predict_taken, if_pred_target};

  // A pending flush clears both slots, which also drops the IF capture.
  bp_pipe_slot u_id_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (1'b1),
    .hold_i  (stall),
    .clear_i (flush_q),
    .d_i     (if_slot),
    .q_o     (id_q)
  );

  bp_pipe_slot u_ex_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (1'b1),
    .hold_i  (stall),
    .clear_i (flush_q),
    .d_i     (id_q),
    .q_o     (ex_q)
  );

  assign resolve    = ex_q.valid && ex_is_branch && !stall && !flush_q;
  assign dir_miss   = ex_q.pred_taken != ex_actual_taken;
  assign tgt_miss   = ex_q.pred_taken && ex_actual_taken &&
                      (ex_q.pred_target != ex_actual_target);
  assign mispredict = resolve && (dir_miss || tgt_miss);

  always_comb begin
    update_en_d    = resolve;
    redirect_d     = mispredict;
    flush_d        = mispredict;
    actual_taken_d = actual_taken_q;
    idx_d          = idx_q;
    redirect_pc_d  = redirect_pc_q;
    if (resolve) begin
      actual_taken_d = ex_actual_taken;
      idx_d          = ex_q.pc[BHT_IDX_LSB +: BHT_IDX_W];
      redirect_pc_d  = ex_actual_taken ? ex_actual_target : ex_q.pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      update_en_q    <= 1'b0;
      actual_taken_q <= 1'b0;
      idx_q          <= '0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
      flush_q        <= 1'b0;
    end else begin
      update_en_q    <= update_en_d;
      actual_taken_q <= actual_taken_d;
      idx_q          <= idx_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
      flush_q        <= flush_d;
    end
  end

  assign bht_update_en    = update_en_q;
  assign bht_actual_taken = actual_taken_q;
  assign bht_pc_index     = idx_q;
  assign redirect_valid   = redirect_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = flush_q;

`ifdef BRANCH_STATS_EN
  logic [XLEN-1:0] branch_cnt_q, branch_cnt_d;
  logic [XLEN-1:0] mispred_cnt_q, mispred_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + XLEN'(1);
    end
    if (mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: table of single-branch transactions plus
// hand sequences for stall, flush shadow, reset mid-flush and counters.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_predict_taken;
  logic [31:0] if_pred_target;
  logic        stall;
  logic        ex_is_branch;
  logic        ex_actual_taken;
  logic [31:0] ex_actual_target;
  logic        bht_update_en;
  logic        bht_actual_taken;
  logic [7:0]  bht_pc_index;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_resolve dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_predict_taken (if_predict_taken),
    .if_pred_target   (if_pred_target),
    .stall            (stall),
    .ex_is_branch     (ex_is_branch),
    .ex_actual_taken  (ex_actual_taken),
    .ex_actual_target (ex_actual_target),
    .bht_update_en    (bht_update_en),
    .bht_actual_taken (bht_actual_taken),
    .bht_pc_index     (bht_pc_index),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        at;
    logic [31:0] atgt;
    logic        exp_miss;
    logic [31:0] exp_rpc;
    logic [7:0]  exp_idx;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_valid         = 1'b0;
    if_pc            = '0;
    if_predict_taken = 1'b0;
    if_pred_target   = '0;
    stall            = 1'b0;
    ex_is_branch     = 1'b0;
    ex_actual_taken  = 1'b0;
    ex_actual_target = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    if_valid         = 1'b1;
    if_pc            = pc;
    if_predict_taken = pt;
    if_pred_target   = ptgt;
  endtask

  task automatic check_quiet(input string name);
    check({name, ".upd"},   32'(bht_update_en), 32'd0);
    check({name, ".redir"}, 32'(redirect_valid), 32'd0);
    check({name, ".flush"}, 32'(flush), 32'd0);
  endtask

  // Fetch one branch, walk it through ID into EX, resolve, check both output cycles.
  task automatic run_vec(input int i);
    fetch(tbl[i].pc, tbl[i].pt, tbl[i].ptgt);
    step();
    if_valid = 1'b0;
    step();
    ex_is_branch     = 1'b1;
    ex_actual_taken  = tbl[i].at;
    ex_actual_target = tbl[i].atgt;
    step();
    ex_is_branch = 1'b0;
    check({tbl[i].name, ".upd"},   32'(bht_update_en), 32'd1);
    check({tbl[i].name, ".idx"},   32'(bht_pc_index), 32'(tbl[i].exp_idx));
    check({tbl[i].name, ".taken"}, 32'(bht_actual_taken), 32'(tbl[i].at));
    check({tbl[i].name, ".redir"}, 32'(redirect_valid), 32'(tbl[i].exp_miss));
    check({tbl[i].name, ".flush"}, 32'(flush), 32'(tbl[i].exp_miss));
    if (tbl[i].exp_miss) check({tbl[i].name, ".rpc"}, redirect_pc, tbl[i].exp_rpc);
    step();
    check_quiet({tbl[i].name, ".after"});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_b, exp_m;

    tbl[0] = '{"correct",  32'h0000_0100, 1'b1, 32'h0000_0140, 1'b1, 32'h0000_0140, 1'b0, 32'h0, 8'h40};
    tbl[1] = '{"dirmiss",  32'h0000_0200, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0280, 1'b1, 32'h0000_0280, 8'h80};
    tbl[2] = '{"tgtmiss",  32'h0000_0300, 1'b1, 32'h0000_0310, 1'b1, 32'h0000_0320, 1'b1, 32'h0000_0320, 8'hC0};
    tbl[3] = '{"wrap",     32'hFFFF_FFFC, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_0000, 8'hFF};
    tbl[4] = '{"nt_ok",    32'h0000_0404, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0500, 1'b0, 32'h0, 8'h01};
    tbl[5] = '{"tk_ok",    32'h0000_07FC, 1'b1, 32'h0000_0800, 1'b1, 32'h0000_0800, 1'b0, 32'h0, 8'hFF};

    idle_inputs();
    reset_n = 1'b0;
    #12;
    check("rst.upd",   32'(bht_update_en), 32'd0);
    check("rst.redir", 32'(redirect_valid), 32'd0);
    check("rst.flush", 32'(flush), 32'd0);
    check("rst.rpc",   redirect_pc, 32'd0);
    check("rst.idx",   32'(bht_pc_index), 32'd0);
    check("rst.bcnt",  branch_count, 32'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(i);

    // Mispredicted branch held three cycles in EX by stall.
    fetch(32'h0000_0500, 1'b0, 32'h0);
    step();
    if_valid = 1'b0;
    step();
    ex_is_branch     = 1'b1;
    ex_actual_taken  = 1'b1;
    ex_actual_target = 32'h0000_0600;
    stall            = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_quiet("stall.held");
    end
    stall = 1'b0;
    step();
    check("stall.upd",   32'(bht_update_en), 32'd1);
    check("stall.redir", 32'(redirect_valid), 32'd1);
    check("stall.rpc",   redirect_pc, 32'h0000_0600);
    step();
    check_quiet("stall.once");
    ex_is_branch = 1'b0;
    step();

    // Miss at 0x600 with a wrong-path branch right behind it.
    fetch(32'h0000_0600, 1'b1, 32'h0000_0700);
    step();
    fetch(32'h0000_0604, 1'b0, 32'h0);
    step();
    if_valid         = 1'b0;
    ex_is_branch     = 1'b1;
    ex_actual_taken  = 1'b0;
    ex_actual_target = 32'h0000_0700;
    step();
    check("shadow.redir", 32'(redirect_valid), 32'd1);
    check("shadow.flush", 32'(flush), 32'd1);
    check("shadow.rpc",   redirect_pc, 32'h0000_0604);
    ex_actual_taken  = 1'b1;
    ex_actual_target = 32'h0000_0900;
    step();
    check_quiet("shadow.ignored");
    step();
    check_quiet("shadow.empty");
    ex_is_branch = 1'b0;
    step();

    // Reset asserted while flush is high, with a valid instruction in ID.
    fetch(32'h0000_0200, 1'b0, 32'h0);
    step();
    if_valid = 1'b0;
    step();
    fetch(32'h0000_0A00, 1'b0, 32'h0);
    ex_is_branch     = 1'b1;
    ex_actual_taken  = 1'b1;
    ex_actual_target = 32'h0000_0280;
    step();
    check("midrst.pre_flush", 32'(flush), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst.flush", 32'(flush), 32'd0);
    check("midrst.redir", 32'(redirect_valid), 32'd0);
    check("midrst.upd",   32'(bht_update_en), 32'd0);
    check("midrst.rpc",   redirect_pc, 32'd0);
    check("midrst.idx",   32'(bht_pc_index), 32'd0);
    check("midrst.taken", 32'(bht_actual_taken), 32'd0);
    check("midrst.mcnt",  mispredict_count, 32'd0);
    if_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check_quiet("postrst.c1");
    step();
    check_quiet("postrst.c2");
    ex_is_branch = 1'b0;
    step();

    // Counters: five branches, two of them mispredicted.
    run_vec(0);
    run_vec(1);
    run_vec(2);
    run_vec(4);
    run_vec(5);
`ifdef BRANCH_STATS_EN
    exp_b = 32'd5;
    exp_m = 32'd2;
`else
    exp_b = 32'd0;
    exp_m = 32'd0;
`endif
    check("stats.branch",  branch_count, exp_b);
    check("stats.mispred", mispredict_count, exp_m);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
